// File: rtl/stage_sample_mixer_if.sv
// rtl/stage_sample_mixer_if.sv - operator input and sample output handshake bundle for stage_sample_mixer
interface stage_sample_mixer_if #(
  parameter int NUM_VOICE_OPERATORS = 256,
  parameter int SAMPLE_WIDTH        = 16,
  parameter int NUM_CHANNELS        = 2
) ();
  logic                                   i_Valid;
  logic [$clog2(NUM_VOICE_OPERATORS)-1:0] i_VoiceOperator;
  logic                                   i_IsCarrier;
  logic [2:0]                             i_NumCarriers;
  logic [NUM_CHANNELS-1:0]                i_ChannelMask;
  logic signed [SAMPLE_WIDTH-1:0]         i_OperatorOutput;
  logic                                   i_SampleReady;
  logic                                   o_SampleValid;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   o_Sample;

  // Producer of operator entries and consumer of mixed samples
  modport master (
    output i_Valid, i_VoiceOperator, i_IsCarrier, i_NumCarriers, i_ChannelMask,
           i_OperatorOutput, i_SampleReady,
    input  o_SampleValid, o_Sample
  );

  // The mixer itself
  modport slave (
    input  i_Valid, i_VoiceOperator, i_IsCarrier, i_NumCarriers, i_ChannelMask,
           i_OperatorOutput, i_SampleReady,
    output o_SampleValid, o_Sample
  );
endinterface

// File: rtl/stage_sample_mixer.sv
// rtl/stage_sample_mixer.sv - carrier compensation, per-channel frame accumulation, saturation and output FIFO
module stage_sample_mixer #(
  parameter int NUM_VOICE_OPERATORS = 256,
  parameter int SAMPLE_WIDTH        = 16,
  parameter int NUM_CHANNELS        = 2,
  parameter int MULT_LATENCY        = 4,
  parameter int OUTPUT_SHIFT        = 5,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_ClearOverflow,
  output logic                o_Overflow,
  stage_sample_mixer_if.slave bus
);
  localparam int SW    = SAMPLE_WIDTH;
  localparam int NC    = NUM_CHANNELS;
  localparam int ML    = MULT_LATENCY;
  localparam int ID_W  = $clog2(NUM_VOICE_OPERATORS);
  localparam int AW    = SW + ID_W;
  localparam int OW    = NC * SW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (SW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  // Compensation factor in Q1.15: min(32767, floor(32768 / carriers))
  logic [15:0] w_factor;
  always_comb begin
    w_factor = 16'h7FFF;
    case (bus.i_NumCarriers)
      3'd0: w_factor = 16'h7FFF;
      3'd1: w_factor = 16'h4000;
      3'd2: w_factor = 16'h2AAA;
      3'd3: w_factor = 16'h2000;
      3'd4: w_factor = 16'h1999;
      3'd5: w_factor = 16'h1555;
      3'd6: w_factor = 16'h1249;
      3'd7: w_factor = 16'h1000;
      default: w_factor = 16'h7FFF;
    endcase
  end

  // Factor is below 1.0, so the shifted product always fits back into SW bits
  logic signed [SW+16:0] w_prod;
  logic signed [SW-1:0]  w_comp;
  logic                  w_last;
  assign w_prod = bus.i_OperatorOutput * $signed({1'b0, w_factor});
  assign w_comp = SW'(w_prod >>> 15);
  assign w_last = (bus.i_VoiceOperator == ID_W'(NUM_VOICE_OPERATORS - 1));

  logic signed [SW-1:0] r_c_pipe    [ML];
  logic [NC-1:0]        r_mask_pipe [ML];
  logic [ML-1:0]        r_v_pipe;
  logic [ML-1:0]        r_car_pipe;
  logic [ML-1:0]        r_last_pipe;

  // Delay the compensated value and its side-band flags by MULT_LATENCY cycles
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_v_pipe    <= '0;
      r_car_pipe  <= '0;
      r_last_pipe <= '0;
      for (int i = 0; i < ML; i++) begin
        r_c_pipe[i]    <= '0;
        r_mask_pipe[i] <= '0;
      end
    end else begin
      r_v_pipe[0]    <= bus.i_Valid;
      r_car_pipe[0]  <= bus.i_IsCarrier;
      r_last_pipe[0] <= w_last;
      r_c_pipe[0]    <= w_comp;
      r_mask_pipe[0] <= bus.i_ChannelMask;
      for (int i = 1; i < ML; i++) begin
        r_v_pipe[i]    <= r_v_pipe[i-1];
        r_car_pipe[i]  <= r_car_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
        r_c_pipe[i]    <= r_c_pipe[i-1];
        r_mask_pipe[i] <= r_mask_pipe[i-1];
      end
    end
  end

  logic                 w_tail_v;
  logic                 w_tail_end;
  logic signed [AW-1:0] r_acc   [NC];
  logic signed [AW-1:0] w_add   [NC];
  logic signed [AW-1:0] w_sum   [NC];
  logic signed [AW-1:0] w_shift [NC];
  logic [OW-1:0]        w_out;
  assign w_tail_v   = r_v_pipe[ML-1];
  assign w_tail_end = w_tail_v & r_last_pipe[ML-1];

  // Per-channel running sum including the current entry, then shift and saturate
  always_comb begin
    w_out = '0;
    for (int c = 0; c < NC; c++) begin
      w_add[c] = '0;
      if (w_tail_v && r_car_pipe[ML-1] && r_mask_pipe[ML-1][c])
        w_add[c] = {{(AW-SW){r_c_pipe[ML-1][SW-1]}}, r_c_pipe[ML-1]};
      w_sum[c]   = r_acc[c] + w_add[c];
      w_shift[c] = w_sum[c] >>> OUTPUT_SHIFT;
      if (w_shift[c] > SAT_MAX)
        w_out[c*SW +: SW] = SW'(SAT_MAX);
      else if (w_shift[c] < SAT_MIN)
        w_out[c*SW +: SW] = SW'(SAT_MIN);
      else
        w_out[c*SW +: SW] = SW'(w_shift[c]);
    end
  end

  logic          r_push_valid;
  logic [OW-1:0] r_push_data;

  // Accumulate carriers; on the last slot register the finished frame and restart from zero
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      for (int c = 0; c < NC; c++) r_acc[c] <= '0;
    end else begin
      r_push_valid <= w_tail_end;
      if (w_tail_end) r_push_data <= w_out;
      for (int c = 0; c < NC; c++) r_acc[c] <= w_tail_end ? '0 : w_sum[c];
    end
  end

  logic [OW-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_drop;
  assign w_pop     = (r_count != '0) & bus.i_SampleReady;
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_ok = r_push_valid & (~w_full | w_pop);
  assign w_drop    = r_push_valid & w_full & ~w_pop;

  // Output FIFO; a full FIFO accepts a push only when the head leaves on the same edge
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear
  always_ff @(posedge i_Clock) begin
    if (i_Reset)              o_Overflow <= 1'b0;
    else if (w_drop)          o_Overflow <= 1'b1;
    else if (i_ClearOverflow) o_Overflow <= 1'b0;
  end

  assign bus.o_SampleValid = (r_count != '0);
  assign bus.o_Sample      = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_stage_sample_mixer.sv
// tb/tb_stage_sample_mixer.sv - randomized self-checking bench for stage_sample_mixer
module tb_stage_sample_mixer;
  localparam int NVO = 256;
  localparam int SW  = 16;
  localparam int NC  = 2;
  localparam int ML  = 4;
  localparam int OS  = 5;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic ovf;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  int   f_op   [NVO];
  int   f_nc   [NVO];
  bit   f_car  [NVO];
  bit [1:0] f_mask [NVO];
  bit   rand_ready = 1'b0;

  stage_sample_mixer_if #(.NUM_VOICE_OPERATORS(NVO), .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC)) bus ();

  stage_sample_mixer #(
    .NUM_VOICE_OPERATORS(NVO), .SAMPLE_WIDTH(SW), .NUM_CHANNELS(NC),
    .MULT_LATENCY(ML), .OUTPUT_SHIFT(OS), .FIFO_DEPTH(FD)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_ClearOverflow(clr), .o_Overflow(ovf), .bus(bus)
  );

  always #5 clk = ~clk;

  // Record every sample the consumer accepts
  always @(negedge clk)
    if (!rst && bus.o_SampleValid && bus.i_SampleReady) got_q.push_back(bus.o_Sample);

  // Reference: frame mix computed directly from the arithmetic rules
  function automatic logic [31:0] model_frame();
    longint acc [NC];
    longint f, c, s;
    logic [31:0] r;
    for (int ch = 0; ch < NC; ch++) acc[ch] = 0;
    for (int i = 0; i < NVO; i++) begin
      if (f_car[i]) begin
        f = 32768 / (f_nc[i] + 1);
        if (f > 32767) f = 32767;
        c = (longint'(f_op[i]) * f) >>> 15;
        for (int ch = 0; ch < NC; ch++) if (f_mask[i][ch]) acc[ch] += c;
      end
    end
    r = '0;
    for (int ch = 0; ch < NC; ch++) begin
      s = acc[ch] >>> OS;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      r[ch*SW +: SW] = 16'(s);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.i_SampleReady = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_zero(input int nc);
    for (int i = 0; i < NVO; i++) begin
      f_op[i] = 0; f_nc[i] = nc; f_car[i] = 1'b0; f_mask[i] = 2'b00;
    end
  endtask

  task automatic fill_random(input int carrier_pct);
    for (int i = 0; i < NVO; i++) begin
      f_op[i]   = int'($urandom_range(0, 65535)) - 32768;
      f_nc[i]   = int'($urandom_range(0, 7));
      f_car[i]  = ($urandom_range(0, 99) < carrier_pct);
      f_mask[i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic send_frame(input int gap_pct, input int upto);
    for (int i = 0; i < upto; i++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        bus.i_Valid          = 1'b0;
        bus.i_VoiceOperator  = 8'($urandom_range(0, 255));
        bus.i_IsCarrier      = 1'b1;
        bus.i_NumCarriers    = 3'($urandom_range(0, 7));
        bus.i_ChannelMask    = 2'b11;
        bus.i_OperatorOutput = 16'($urandom_range(0, 65535));
        tick();
      end
      bus.i_Valid          = 1'b1;
      bus.i_VoiceOperator  = 8'(i);
      bus.i_IsCarrier      = f_car[i];
      bus.i_NumCarriers    = 3'(f_nc[i]);
      bus.i_ChannelMask    = f_mask[i];
      bus.i_OperatorOutput = 16'(f_op[i]);
      tick();
    end
    bus.i_Valid = 1'b0;
  endtask

  task automatic wait_samples(input int n);
    int cyc = 0;
    while (got_q.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.o_SampleValid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.o_SampleValid);
    end
    tests_run++;
    if (bus.o_Sample !== 32'h0) begin
      tests_failed++; $display("FAIL reset_sample: got %h expected 00000000", bus.o_Sample);
    end
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_overflow: got %b expected 0", ovf);
    end
    tick();
  endtask

  task automatic test_mono();
    int n;
    fill_zero(0);
    f_car[3] = 1'b1; f_op[3] = 16'h4000; f_mask[3] = 2'b01;
    got_q.delete();
    send_frame(0, NVO);
    n = 1;
    @(negedge clk);
    while (!bus.o_SampleValid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n !== ML + 2) begin
      tests_failed++; $display("FAIL mono_latency: got %0d cycles expected %0d", n, ML + 2);
    end
    wait_samples(1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0000_01FF) begin
      tests_failed++;
      $display("FAIL mono_sample: got %h (count %0d) expected 000001ff",
               got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size());
    end
  endtask

  task automatic test_stereo();
    fill_zero(1);
    f_car[10]  = 1'b1; f_op[10]  = 8000;  f_mask[10]  = 2'b01;
    f_car[200] = 1'b1; f_op[200] = -8000; f_mask[200] = 2'b10;
    got_q.delete();
    send_frame(0, NVO);
    wait_samples(1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== {16'hFF83, 16'h007D}) begin
      tests_failed++;
      $display("FAIL stereo_route: got %h (count %0d) expected ff83007d",
               got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size());
    end
  endtask

  task automatic test_saturation();
    got_q.delete();
    fill_zero(0);
    for (int i = 0; i < NVO; i++) begin f_car[i] = 1'b1; f_op[i] = 32767; f_mask[i] = 2'b11; end
    send_frame(0, NVO);
    for (int i = 0; i < NVO; i++) f_op[i] = -32768;
    send_frame(0, NVO);
    wait_samples(2);
    tests_run++;
    if (got_q.size() < 1 || got_q[0] !== 32'h7FFF_7FFF) begin
      tests_failed++;
      $display("FAIL sat_pos: got %h expected 7fff7fff", got_q.size() > 0 ? got_q[0] : 32'hx);
    end
    tests_run++;
    if (got_q.size() < 2 || got_q[1] !== 32'h8000_8000) begin
      tests_failed++;
      $display("FAIL sat_neg: got %h expected 80008000", got_q.size() > 1 ? got_q[1] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    exp_q.delete();
    bus.i_SampleReady = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fill_random(40);
      exp_q.push_back(model_frame());
      send_frame(0, NVO);
      repeat (ML + 4) tick();
      @(negedge clk);
      tests_run++;
      if (ovf !== (k >= 4)) begin
        tests_failed++; $display("FAIL bp_overflow_frame%0d: got %b expected %b", k, ovf, k >= 4);
      end
      tests_run++;
      if (bus.o_SampleValid !== 1'b1 || bus.o_Sample !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL bp_head_hold_frame%0d: got valid %b data %h expected valid 1 data %h",
                 k, bus.o_SampleValid, bus.o_Sample, exp_q[0]);
      end
    end
    tick();
    bus.i_SampleReady = 1'b1;
    wait_samples(4);
    repeat (10) tick();
    tests_run++;
    if (got_q.size() != 4) begin
      tests_failed++; $display("FAIL bp_pop_count: got %0d expected 4", got_q.size());
    end
    for (int j = 0; j < 4 && j < got_q.size(); j++) begin
      tests_run++;
      if (got_q[j] !== exp_q[j]) begin
        tests_failed++; $display("FAIL bp_order%0d: got %h expected %h", j, got_q[j], exp_q[j]);
      end
    end
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++; $display("FAIL bp_sticky: got %b expected 1", ovf);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++; $display("FAIL bp_clear: got %b expected 0", ovf);
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] exp;
    got_q.delete();
    fill_random(60);
    exp = model_frame();
    send_frame(35, NVO);
    send_frame(0, NVO);
    wait_samples(2);
    for (int j = 0; j < 2; j++) begin
      tests_run++;
      if (got_q.size() <= j || got_q[j] !== exp) begin
        tests_failed++;
        $display("FAIL bubbles_frame%0d: got %h expected %h", j,
                 got_q.size() > j ? got_q[j] : 32'hx, exp);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp;
    fill_random(80);
    send_frame(0, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    @(negedge clk);
    tests_run++;
    if (bus.o_SampleValid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_valid: got %b expected 0", bus.o_SampleValid);
    end
    fill_random(70);
    exp = model_frame();
    send_frame(10, NVO);
    wait_samples(1);
    repeat (5) tick();
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== exp) begin
      tests_failed++;
      $display("FAIL midreset_frame: got %h (count %0d) expected %h",
               got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size(), exp);
    end
  endtask

  task automatic test_random_frames();
    got_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fill_random(int'($urandom_range(10, 100)));
      exp_q.push_back(model_frame());
      send_frame(10, NVO);
    end
    rand_ready = 1'b0;
    bus.i_SampleReady = 1'b1;
    wait_samples(5);
    for (int j = 0; j < 5; j++) begin
      tests_run++;
      if (got_q.size() <= j || got_q[j] !== exp_q[j]) begin
        tests_failed++;
        $display("FAIL random_frame%0d: got %h expected %h", j,
                 got_q.size() > j ? got_q[j] : 32'hx, exp_q[j]);
      end
    end
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++; $display("FAIL random_no_overflow: got %b expected 0", ovf);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.i_Valid          = 1'b0;
    bus.i_VoiceOperator  = '0;
    bus.i_IsCarrier      = 1'b0;
    bus.i_NumCarriers    = '0;
    bus.i_ChannelMask    = '0;
    bus.i_OperatorOutput = '0;
    bus.i_SampleReady    = 1'b1;
    test_reset();
    test_mono();
    test_stereo();
    test_saturation();
    test_backpressure();
    test_bubbles();
    test_reset_midframe();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
